// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch sequencer.
// The ROM geometry and reset PC live here so the ROM wrapper and the sequencer agree.
package fetch_sequencer_pkg;

  localparam int          PC_W_DEF      = 16;
  localparam int          ROM_WORDS_DEF = 15;
  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [3:0]  HALT_OP_DEF   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Byte PC maps to word index pc>>1; anything at or beyond the loaded image is a fault.
  function automatic logic pc_in_range(input logic [PC_W_DEF-1:0] pc, input int words);
    return (pc >> 1) < PC_W_DEF'(words);
  endfunction

  // Branch targets are word aligned; bit 0 of the request is dropped.
  function automatic logic [PC_W_DEF-1:0] align_pc(input logic [PC_W_DEF-1:0] pc);
    return pc & ~PC_W_DEF'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: ROM address/data, decode handshake, redirect and status.
// master = the sequencer, slave = the parent that owns the ROM and decode stage.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic                run_i;
  logic [PC_W_DEF-1:0] pc_o;
  logic [PC_W_DEF-1:0] rom_instr_i;
  logic [PC_W_DEF-1:0] instr_o;
  logic [PC_W_DEF-1:0] instr_pc_o;
  logic                instr_valid_o;
  logic                instr_ready_i;
  logic                redirect_i;
  logic [PC_W_DEF-1:0] redirect_pc_i;
  logic                halted_o;
  logic                fault_o;

  modport master (
    input  run_i, rom_instr_i, instr_ready_i, redirect_i, redirect_pc_i,
    output pc_o, instr_o, instr_pc_o, instr_valid_o, halted_o, fault_o
  );

  modport slave (
    output run_i, rom_instr_i, instr_ready_i, redirect_i, redirect_pc_i,
    input  pc_o, instr_o, instr_pc_o, instr_valid_o, halted_o, fault_o
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC register, one-entry fetch slot and IDLE/FETCH/HALT FSM.
// Presents pc_o to a combinational ROM and captures the returned word when the slot frees up.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEF,
  parameter int          ROM_WORDS = ROM_WORDS_DEF,
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [3:0]  HALT_OP   = HALT_OP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] instr_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            valid_q;
  logic            fault_q;

  logic slot_free;
  logic accept;
  logic fetch_ok;
  logic is_halt_op;

  // Slot frees either because it is empty or because decode takes it this cycle.
  assign accept     = valid_q & bus.instr_ready_i;
  assign slot_free  = ~valid_q | bus.instr_ready_i;
  assign fetch_ok   = pc_in_range(pc_q, ROM_WORDS);
  assign is_halt_op = (bus.rom_instr_i[PC_W-1:PC_W-4] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run_i) state <= FETCH;
        end

        FETCH: begin
          if (bus.redirect_i) begin
            pc_q    <= align_pc(bus.redirect_pc_i);
            valid_q <= 1'b0;
          end else if (slot_free) begin
            if (!fetch_ok) begin
              // Faulting address is kept on pc_o for post-mortem.
              fault_q <= 1'b1;
              valid_q <= 1'b0;
              state   <= HALT;
            end else begin
              instr_q    <= bus.rom_instr_i;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              if (is_halt_op) state <= HALT;
              else            pc_q  <= pc_q + PC_W'(2);
            end
          end
        end

        HALT: begin
          if (bus.redirect_i) begin
            pc_q    <= align_pc(bus.redirect_pc_i);
            valid_q <= 1'b0;
            state   <= FETCH;
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.fault_o       = fault_q;
  assign bus.halted_o      = (state == HALT) & ~valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural fetch model checked every cycle.
module tb_fetch_sequencer;

  localparam int ROM_WORDS = 15;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [15:0] rom [16];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .PC_W      (16),
    .ROM_WORDS (ROM_WORDS),
    .RESET_PC  (16'h0000),
    .HALT_OP   (4'b1111)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_instr_i = rom[bus.pc_o[4:1]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: program counter, a single delivery slot, and run/stop/fault flags.
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_started, m_stopped, m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 16'h0000; m_instr <= 16'h0; m_ipc <= 16'h0;
      m_valid <= 1'b0; m_started <= 1'b0; m_stopped <= 1'b0; m_fault <= 1'b0;
    end else if (!m_started) begin
      m_started <= bus.run_i;
    end else if (bus.redirect_i) begin
      m_pc      <= {bus.redirect_pc_i[15:1], 1'b0};
      m_valid   <= 1'b0;
      m_stopped <= 1'b0;
    end else if (m_stopped) begin
      if (m_valid && bus.instr_ready_i) m_valid <= 1'b0;
    end else if (!m_valid || bus.instr_ready_i) begin
      if (int'(m_pc) / 2 >= ROM_WORDS) begin
        m_fault   <= 1'b1;
        m_stopped <= 1'b1;
        m_valid   <= 1'b0;
      end else begin
        m_instr <= rom[m_pc[4:1]];
        m_ipc   <= m_pc;
        m_valid <= 1'b1;
        if (rom[m_pc[4:1]][15:12] == 4'hF) m_stopped <= 1'b1;
        else                               m_pc      <= m_pc + 16'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_pc",     32'(bus.pc_o),          32'(m_pc));
      chk("cyc_valid",  32'(bus.instr_valid_o), 32'(m_valid));
      chk("cyc_halted", 32'(bus.halted_o),      32'(m_stopped && !m_valid));
      chk("cyc_fault",  32'(bus.fault_o),       32'(m_fault));
      if (m_valid) begin
        chk("cyc_instr", 32'(bus.instr_o),    32'(m_instr));
        chk("cyc_ipc",   32'(bus.instr_pc_o), 32'(m_ipc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [15:0] target);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = target;
    tick();
    bus.redirect_i    = 1'b0;
  endtask

  task automatic chk_slot(input string name, input logic [15:0] instr, input logic [15:0] ipc,
                          input logic [15:0] pc);
    chk({name, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
    chk({name, "_instr"}, 32'(bus.instr_o),       32'(instr));
    chk({name, "_ipc"},   32'(bus.instr_pc_o),    32'(ipc));
    chk({name, "_pc"},    32'(bus.pc_o),          32'(pc));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h1001 + 16'(i);
    rom[5] = 16'hF000;

    rst = 1'b1;
    bus.run_i = 1'b0; bus.instr_ready_i = 1'b0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 16'h0;
    repeat (2) tick();
    chk("rst_pc",     32'(bus.pc_o),          32'h0);
    chk("rst_valid",  32'(bus.instr_valid_o), 32'h0);
    chk("rst_instr",  32'(bus.instr_o),       32'h0);
    chk("rst_halted", 32'(bus.halted_o),      32'h0);
    chk("rst_fault",  32'(bus.fault_o),       32'h0);

    // Start and stream three words back to back
    rst = 1'b0; bus.run_i = 1'b1; bus.instr_ready_i = 1'b1;
    tick();
    chk("start_valid", 32'(bus.instr_valid_o), 32'h0);
    tick(); chk_slot("s0", 16'h1001, 16'h0000, 16'h0002);
    tick(); chk_slot("s1", 16'h1002, 16'h0002, 16'h0004);
    tick(); chk_slot("s2", 16'h1003, 16'h0004, 16'h0006);

    // Backpressure on 1002@2
    redirect_to(16'h0002);
    chk("bp_flush", 32'(bus.instr_valid_o), 32'h0);
    tick(); chk_slot("bp_cap", 16'h1002, 16'h0002, 16'h0004);
    bus.instr_ready_i = 1'b0;
    repeat (3) begin
      tick(); chk_slot("bp_hold", 16'h1002, 16'h0002, 16'h0004);
    end
    bus.instr_ready_i = 1'b1;
    tick(); chk_slot("bp_rel", 16'h1003, 16'h0004, 16'h0006);

    // Redirect with odd target while slot is full
    redirect_to(16'h0013);
    chk("rd_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rd_pc",    32'(bus.pc_o),          32'h0012);
    tick(); chk_slot("rd_cap", 16'h100A, 16'h0012, 16'h0014);

    // Halt opcode at word 5
    redirect_to(16'h0008);
    tick(); chk_slot("h_w4", 16'h1005, 16'h0008, 16'h000A);
    tick(); chk_slot("h_w5", 16'hF000, 16'h000A, 16'h000A);
    chk("h_not_yet", 32'(bus.halted_o), 32'h0);
    tick();
    chk("h_halted", 32'(bus.halted_o),      32'h1);
    chk("h_empty",  32'(bus.instr_valid_o), 32'h0);
    tick();
    chk("h_pc_hold", 32'(bus.pc_o), 32'h000A);
    redirect_to(16'h0000);
    chk("h_restart", 32'(bus.halted_o), 32'h0);
    tick(); chk_slot("h_w0", 16'h1001, 16'h0000, 16'h0002);

    // Redirect coinciding with the halt-word capture wins
    redirect_to(16'h000A);
    redirect_to(16'h0004);
    chk("rh_valid",  32'(bus.instr_valid_o), 32'h0);
    chk("rh_pc",     32'(bus.pc_o),          32'h0004);
    tick(); chk_slot("rh_cap", 16'h1003, 16'h0004, 16'h0006);

    // Out-of-range fetch at word 15
    redirect_to(16'h001E);
    chk("f_pre", 32'(bus.fault_o), 32'h0);
    tick();
    chk("f_fault",  32'(bus.fault_o),       32'h1);
    chk("f_halted", 32'(bus.halted_o),      32'h1);
    chk("f_valid",  32'(bus.instr_valid_o), 32'h0);
    chk("f_pc",     32'(bus.pc_o),          32'h001E);
    redirect_to(16'h0000);
    tick(); chk_slot("f_resume", 16'h1001, 16'h0000, 16'h0002);
    chk("f_sticky", 32'(bus.fault_o), 32'h1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("ar_pc",    32'(bus.pc_o),          32'h0);
    chk("ar_instr", 32'(bus.instr_o),       32'h0);
    chk("ar_fault", 32'(bus.fault_o),       32'h0);
    tick();

    // IDLE ignores redirect when run is low
    rst = 1'b0; bus.run_i = 1'b0;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 16'h0008;
    repeat (2) tick();
    bus.redirect_i = 1'b0;
    chk("idle_pc",    32'(bus.pc_o),          32'h0);
    chk("idle_valid", 32'(bus.instr_valid_o), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
